// File: rtl/uart.sv
// Full-duplex 8N1 UART: a tick-paced transmitter and a 16x-oversampling receiver
// with a sticky ready flag, one shared clock and asynchronous active-high reset.
module uart #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout
);

  localparam int TX_DIV = CLK_HZ / BAUD;
  localparam int RX_DIV = CLK_HZ / (16 * BAUD);
  localparam int TX_CW  = $clog2(TX_DIV + 1);
  localparam int RX_CW  = $clog2(RX_DIV + 1);

  localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(TX_DIV - 1);
  localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_DIV - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Baud dividers
  logic [TX_CW-1:0] r_tx_div;
  logic [RX_CW-1:0] r_rx_div;
  logic             w_tx_tick;
  logic             w_rx_tick;

  assign w_tx_tick = (r_tx_div == TX_LAST);
  assign w_rx_tick = (r_rx_div == RX_LAST);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values they held before the edge.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_tx_div <= '0;
    end else if (w_tx_tick) begin
      r_tx_div <= '0;
    end else begin
      r_tx_div <= r_tx_div + TX_CW'(1);
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_rx_div <= '0;
    end else if (w_rx_tick) begin
      r_rx_div <= '0;
    end else begin
      r_rx_div <= r_rx_div + RX_CW'(1);
    end
  end

  // Transmitter
  logic [1:0] r_tx_state;
  logic [7:0] r_tx_shift;
  logic [3:0] r_tx_bit;
  logic       r_tx;
  logic       r_tx_busy;

  // States name what the next tx_tick does: START drives the start bit, DATA
  // drives the eight data bits, STOP drives the stop bit and then ends it.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= 8'h00;
      r_tx_bit   <= 4'd0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (wr_en) begin
            r_tx_shift <= din;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx       <= 1'b0;
            r_tx_bit   <= 4'd0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 4'd1;
            if (r_tx_bit == 4'd7) begin
              r_tx_state <= TX_STOP;
            end
          end
        end
        TX_STOP: begin
          if (w_tx_tick) begin
            if (r_tx_bit == 4'd8) begin
              r_tx     <= 1'b1;
              r_tx_bit <= 4'd9;
            end else begin
              r_tx_busy  <= 1'b0;
              r_tx_state <= TX_IDLE;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_tx_busy;

  // Receiver
  logic       r_rx_s1;
  logic       r_rx_s2;
  logic       w_rx;
  logic [1:0] r_rx_state;
  logic [3:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic       w_rx_done;

  // NOTE: rx is asynchronous; nothing but this synchroniser may look at it.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx = r_rx_s2;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_rx_tick) begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_rx_cnt   <= 4'd0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == 4'd7) begin
            if (!w_rx) begin
              r_rx_cnt   <= 4'd0;
              r_rx_bit   <= 3'd0;
              r_rx_state <= RX_DATA;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
          end
        end
        RX_DATA: begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_rx_done = w_rx_tick && (r_rx_state == RX_STOP) && (r_rx_cnt == 4'd15) && w_rx;

  // A completing byte takes priority over a clear arriving on the same edge.
  logic       r_rdy;
  logic [7:0] r_dout;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_rdy  <= 1'b0;
      r_dout <= 8'h00;
    end else if (w_rx_done) begin
      r_rdy  <= 1'b1;
      r_dout <= r_rx_shift;
    end else if (rdy_clr) begin
      r_rdy <= 1'b0;
    end
  end

  assign rdy  = r_rdy;
  assign dout = r_dout;

endmodule

// File: tb/tb_uart.sv
// Randomised self-checking bench for uart: loopback, frame timing, busy
// rejection, sticky ready handling, line errors and reset mid-frame.
module tb_uart;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       wr_en;
  logic       tx;
  logic       tx_busy;
  logic       rx_line;
  logic       rdy;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       tb_rx;
  logic       use_loop;

  assign rx_line = use_loop ? tx : tb_rx;

  uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .din     (din),
    .wr_en   (wr_en),
    .tx      (tx),
    .tx_busy (tx_busy),
    .rx      (rx_line),
    .rdy     (rdy),
    .rdy_clr (rdy_clr),
    .dout    (dout)
  );

  always #5 clk_50m = ~clk_50m;

  int         n_vec = 0;
  int         n_err = 0;
  logic       m_rdy;
  logic [7:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rdy"}, rdy, m_rdy);
    check({tag, "_dout"}, dout, m_dout);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 40 * BIT) begin
      @(negedge clk_50m);
      n++;
    end
    check({tag, "_idle"}, tx_busy, 0);
  endtask

  task automatic strobe(input logic [7:0] d);
    @(posedge clk_50m); #1;
    din   = d;
    wr_en = 1'b1;
    @(posedge clk_50m); #1;
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    wait_idle(tag);
    strobe(d);
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    @(negedge clk_50m);
    while (rdy !== 1'b1 && n < 20 * BIT) begin
      @(negedge clk_50m);
      n++;
    end
    check({tag, "_rdy"}, rdy, 1);
  endtask

  task automatic wait_tx_fall(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 4 * BIT) begin
      @(negedge clk_50m);
      n++;
    end
    check({tag, "_start"}, tx, 0);
  endtask

  task automatic clear_rdy(input string tag);
    @(posedge clk_50m); #1;
    rdy_clr = 1'b1;
    @(posedge clk_50m); #1;
    rdy_clr = 1'b0;
    m_rdy   = 1'b0;
    check({tag, "_clr"}, rdy, 0);
  endtask

  // Loopback transfer: the byte has been received once the transmitter is idle.
  task automatic xfer(input logic [7:0] d, input string tag);
    send(d, tag);
    wait_idle(tag);
    idle(4);
    m_rdy  = 1'b1;
    m_dout = d;
    check_model(tag);
  endtask

  task automatic frame_check(input logic [7:0] d);
    int   k;
    int   b;
    logic e;
    send(d, "ff");
    wait_tx_fall("ff");
    k = 0;
    while (tx_busy === 1'b1 && k < 12 * BIT) begin
      if (k % BIT == BIT / 2 && k / BIT < 10) begin
        b = k / BIT;
        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : 1'((int'(d) >> (b - 1)) & 1);
        check($sformatf("ff_%02h_bit%0d", d, b), tx, e);
      end
      @(negedge clk_50m);
      k++;
    end
    check($sformatf("ff_%02h_len", d), k, 10 * BIT);
    check($sformatf("ff_%02h_txidle", d), tx, 1);
    m_rdy  = 1'b1;
    m_dout = d;
    idle(4);
    check_model($sformatf("ff_%02h", d));
    clear_rdy("ff");
  endtask

  // Bench-driven serial frame; a bad stop bit is held low only through its
  // middle so the line is high again before a false start could be confirmed.
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    for (int b = 0; b < 10; b++) begin
      @(posedge clk_50m); #1;
      tb_rx = (b == 0) ? 1'b0 : (b == 9) ? stop : 1'((int'(d) >> (b - 1)) & 1);
      if (b == 9 && !stop) begin
        repeat ((3 * BIT) / 4 - 1) @(posedge clk_50m);
        #1 tb_rx = 1'b1;
        repeat (BIT - (3 * BIT) / 4) @(posedge clk_50m);
      end else begin
        repeat (BIT - 1) @(posedge clk_50m);
      end
    end
    #1 tb_rx = 1'b1;
    idle(2 * BIT);
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    int         n;

    rst      = 1'b1;
    din      = 8'h00;
    wr_en    = 1'b0;
    rdy_clr  = 1'b0;
    tb_rx    = 1'b1;
    use_loop = 1'b1;
    m_rdy    = 1'b0;
    m_dout   = 8'h00;

    repeat (3) @(negedge clk_50m);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check_model("rst");
    rst = 1'b0;
    idle(5);

    // Frame format: fixed pattern plus one random byte
    frame_check(8'hA5);
    frame_check(8'($urandom_range(0, 255)));

    // Busy rejection: a write mid-frame and a write on the cycle busy rises
    send(8'h3C, "bz");
    idle($urandom_range(10, 8 * BIT));
    strobe(8'hFF);
    wait_idle("bz");
    idle(4);
    m_rdy  = 1'b1;
    m_dout = 8'h3C;
    check_model("bz");
    clear_rdy("bz");
    idle(20 * BIT);
    check("bz_nofollow_busy", tx_busy, 0);
    check("bz_nofollow_rdy", rdy, 0);

    r = 8'($urandom_range(0, 255));
    wait_idle("bz2");
    @(posedge clk_50m); #1;
    din   = r;
    wr_en = 1'b1;
    @(posedge clk_50m); #1;
    din   = ~r;
    @(posedge clk_50m); #1;
    wr_en = 1'b0;
    wait_idle("bz2");
    idle(4);
    m_rdy  = 1'b1;
    m_dout = r;
    check_model("bz2");
    clear_rdy("bz2");
    idle(20 * BIT);
    check("bz2_nofollow", tx_busy, 0);

    // Sticky ready, overrun and clear
    xfer(8'h55, "r55");
    idle(50);
    check_model("r55_hold");
    xfer(8'h66, "r66");
    clear_rdy("r66");
    check_model("r66_after_clr");

    // Clear held across the completion edge: the set must win
    r = 8'($urandom_range(0, 255));
    wait_idle("race");
    rdy_clr = 1'b1;
    strobe(r);
    n = 0;
    while (rdy !== 1'b1 && n < 20 * BIT) begin
      @(negedge clk_50m);
      n++;
    end
    rdy_clr = 1'b0;
    m_rdy   = 1'b1;
    m_dout  = r;
    check_model("race");
    idle(3);
    check_model("race_hold");
    clear_rdy("race");

    // Loopback sweep of every byte value
    for (int v = 0; v < 256; v++) begin
      send(8'(v), "lb");
      wait_rdy("lb");
      check($sformatf("lb_%02h", v), dout, v);
      m_dout = 8'(v);
      clear_rdy("lb");
      idle($urandom_range(0, 3));
    end

    // Line errors on a bench-driven rx
    wait_idle("le");
    tb_rx    = 1'b1;
    use_loop = 1'b0;
    idle(4);
    tb_rx = 1'b0;
    idle(4);
    tb_rx = 1'b1;
    idle(20 * BIT);
    check_model("glitch");
    drive_frame(8'($urandom_range(0, 255)), 1'b0);
    check_model("ferr");
    drive_frame(8'h81, 1'b1);
    m_rdy  = 1'b1;
    m_dout = 8'h81;
    check_model("v81");

    // Reset during data bit 3 of a looped-back frame
    use_loop = 1'b1;
    idle(2);
    send(8'($urandom_range(0, 255)), "mr");
    wait_tx_fall("mr");
    repeat (4 * BIT + BIT / 2) @(negedge clk_50m);
    rst = 1'b1;
    #1;
    m_rdy  = 1'b0;
    m_dout = 8'h00;
    check("mr_tx", tx, 1);
    check("mr_busy", tx_busy, 0);
    check_model("mr");
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    idle(5);
    send(8'h7E, "mr7e");
    wait_rdy("mr7e");
    check("mr7e_dout", dout, 8'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
